// File: rtl/ex_operand_stage_if.sv
// Bundle of the ID/EX operand stage signals: decoded ID fields, hazard-unit
// controls, downstream forwarding sources and the EX-stage outputs.
// The master side feeds the stage; the slave side is the stage itself.
interface ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // Hazard / branch unit controls
    logic              stall;
    logic              flush;

    // Decoded instruction from ID
    logic              id_valid;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_shamt;
    logic [3:0]        id_alu_op;
    logic              id_src_a;
    logic              id_src_b;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;

    // Forwarding sources from later stages
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_dst;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_dst;
    logic [DATA_W-1:0] memwb_data;

    // EX-stage outputs
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_valid;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;

    modport master (
        output stall, flush,
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
        output id_imm, id_shamt, id_alu_op, id_src_a, id_src_b, id_dst,
        output id_reg_write, id_mem_read, id_mem_write,
        output exmem_reg_write, exmem_dst, exmem_result,
        output memwb_reg_write, memwb_dst, memwb_data,
        input  alu_in1, alu_in2, alu_op, ex_store_data, ex_dst,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_valid,
        input  fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
        input  id_imm, id_shamt, id_alu_op, id_src_a, id_src_b, id_dst,
        input  id_reg_write, id_mem_read, id_mem_write,
        input  exmem_reg_write, exmem_dst, exmem_result,
        input  memwb_reg_write, memwb_dst, memwb_data,
        output alu_in1, alu_in2, alu_op, ex_store_data, ex_dst,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_valid,
        output fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW-hazard operand forwarding.
// Captures decoded operands/control from ID, bypasses results from EX/MEM
// and MEM/WB, and drives the ALU operands and opcode directly.
// Flush inserts a bubble; stall holds the instruction but keeps refreshing
// the stored source data with forwarded values so a producer retiring
// from MEM/WB during the stall is not lost.
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_operand_stage_if.slave bus
);

    // EX-stage state
    logic              r_valid;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_shamt;
    logic [3:0]        r_alu_op;
    logic              r_src_a;
    logic              r_src_b;
    logic [REG_AW-1:0] r_dst;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    // Forwarding network
    logic              w_exm_hit_a;
    logic              w_exm_hit_b;
    logic              w_mwb_hit_a;
    logic              w_mwb_hit_b;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;
    logic [DATA_W-1:0] w_in1;
    logic [DATA_W-1:0] w_in2;

    // A hit needs a live instruction in EX and a non-zero matching destination;
    // register 0 is hardwired and must never be bypassed.
    assign w_exm_hit_a = r_valid & bus.exmem_reg_write &
                         (bus.exmem_dst != {REG_AW{1'b0}}) & (bus.exmem_dst == r_rs_addr);
    assign w_exm_hit_b = r_valid & bus.exmem_reg_write &
                         (bus.exmem_dst != {REG_AW{1'b0}}) & (bus.exmem_dst == r_rt_addr);
    assign w_mwb_hit_a = r_valid & bus.memwb_reg_write &
                         (bus.memwb_dst != {REG_AW{1'b0}}) & (bus.memwb_dst == r_rs_addr);
    assign w_mwb_hit_b = r_valid & bus.memwb_reg_write &
                         (bus.memwb_dst != {REG_AW{1'b0}}) & (bus.memwb_dst == r_rt_addr);

    // ID/EX register: reset > flush > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= 5'd0;
            r_alu_op    <= 4'd0;
            r_src_a     <= 1'b0;
            r_src_b     <= 1'b0;
            r_dst       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= 5'd0;
            r_alu_op    <= 4'd0;
            r_src_a     <= 1'b0;
            r_src_b     <= 1'b0;
            r_dst       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.stall) begin
            // Hold the instruction but absorb any bypassed value now.
            r_rs_data   <= w_fwd_rs;
            r_rt_data   <= w_fwd_rt;
        end else begin
            r_valid     <= bus.id_valid;
            r_rs_addr   <= bus.id_rs_addr;
            r_rt_addr   <= bus.id_rt_addr;
            r_rs_data   <= bus.id_rs_data;
            r_rt_data   <= bus.id_rt_data;
            r_imm       <= bus.id_imm;
            r_shamt     <= bus.id_shamt;
            r_alu_op    <= bus.id_alu_op;
            r_src_a     <= bus.id_src_a;
            r_src_b     <= bus.id_src_b;
            r_dst       <= bus.id_dst;
            r_reg_write <= bus.id_reg_write;
            r_mem_read  <= bus.id_mem_read;
            r_mem_write <= bus.id_mem_write;
        end
    end

    // Source A bypass select: EX/MEM is newer than MEM/WB so it wins.
    always_comb begin
        w_sel_a  = 2'd0;
        w_fwd_rs = r_rs_data;
        if (w_exm_hit_a) begin
            w_sel_a  = 2'd1;
            w_fwd_rs = bus.exmem_result;
        end else if (w_mwb_hit_a) begin
            w_sel_a  = 2'd2;
            w_fwd_rs = bus.memwb_data;
        end else begin
            w_sel_a  = 2'd0;
            w_fwd_rs = r_rs_data;
        end
    end

    // Source B bypass select, same priority as source A.
    always_comb begin
        w_sel_b  = 2'd0;
        w_fwd_rt = r_rt_data;
        if (w_exm_hit_b) begin
            w_sel_b  = 2'd1;
            w_fwd_rt = bus.exmem_result;
        end else if (w_mwb_hit_b) begin
            w_sel_b  = 2'd2;
            w_fwd_rt = bus.memwb_data;
        end else begin
            w_sel_b  = 2'd0;
            w_fwd_rt = r_rt_data;
        end
    end

    // ALU operand muxes: shamt / immediate override the forwarded register value.
    always_comb begin
        w_in1 = w_fwd_rs;
        w_in2 = w_fwd_rt;
        if (r_src_a) begin
            w_in1 = {{(DATA_W-5){1'b0}}, r_shamt};
        end else begin
            w_in1 = w_fwd_rs;
        end
        if (r_src_b) begin
            w_in2 = r_imm;
        end else begin
            w_in2 = w_fwd_rt;
        end
    end

    // Outputs: control bits are qualified by valid so a bubble has no side effects.
    assign bus.alu_in1       = w_in1;
    assign bus.alu_in2       = w_in2;
    assign bus.alu_op        = r_alu_op;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_dst        = r_dst;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_reg_write  = r_reg_write & r_valid;
    assign bus.ex_mem_read   = r_mem_read  & r_valid;
    assign bus.ex_mem_write  = r_mem_write & r_valid;
    assign bus.fwd_a_sel     = w_sel_a;
    assign bus.fwd_b_sel     = w_sel_b;

endmodule
